// File: rtl/nonce_search_pkg.sv
// Shared widths, FSM state encoding and the target comparison used by the
// nonce search sequencer.
package nonce_search_pkg;

  localparam int NONCE_W  = 32;
  localparam int HASH_W   = 24;
  localparam int TARGET_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // hash[HASH_W-1 -: TARGET_W] < target is the same as comparing the whole
  // hash against the target shifted up into the top bits: the low hash bits
  // can never close the gap of a full target step.
  function automatic logic hash_meets_target(input logic [HASH_W-1:0]   hash,
                                             input logic [TARGET_W-1:0] target);
    return hash < {target, {(HASH_W-TARGET_W){1'b0}}};
  endfunction

endpackage

// File: rtl/nonce_counter.sv
// Candidate nonce counter: loads the first nonce, steps by one and saturates
// at the last nonce so the sweep never wraps.
module nonce_counter
  import nonce_search_pkg::*;
#(
  parameter logic [NONCE_W-1:0] START = '0,
  parameter logic [NONCE_W-1:0] LAST  = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               inc,
  output logic [NONCE_W-1:0] value,
  output logic               is_last
);

  logic [NONCE_W-1:0] value_q;
  logic [NONCE_W-1:0] value_d;

  // Next count: load wins over increment, increment stops at LAST.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = START;
    end else if (inc && (value_q != LAST)) begin
      value_d = value_q + NONCE_W'(1);
    end
  end

  // Count register, returns to the first nonce on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= START;
    end else begin
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign is_last = (value_q == LAST);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce search sequencer: sweeps candidate nonces through the hash engine and
// reports the first nonce whose hash falls below the target, or exhaustion.
module nonce_search_ctrl
  import nonce_search_pkg::*;
#(
  parameter logic [NONCE_W-1:0] NONCE_START = '0,
  parameter logic [NONCE_W-1:0] NONCE_LAST  = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [TARGET_W-1:0] target,
  output logic                finish,
  output logic                found,
  output logic [7:0]          nonce0,
  output logic [7:0]          nonce1,
  output logic [7:0]          nonce2,
  output logic [7:0]          nonce3,
  output logic                hash_start,
  output logic [NONCE_W-1:0]  hash_nonce,
  input  logic                hash_done,
  input  logic [HASH_W-1:0]   hash_out
);

  state_t              state_q,      state_d;
  logic [TARGET_W-1:0] target_q,     target_d;
  logic [HASH_W-1:0]   hash_q,       hash_d;
  logic                finish_q,     finish_d;
  logic                found_q,      found_d;
  logic [NONCE_W-1:0]  result_q,     result_d;
  logic                hash_start_q, hash_start_d;

  logic                cnt_load;
  logic                cnt_inc;
  logic [NONCE_W-1:0]  cnt_value;
  logic                cnt_last;
  logic                win;

  nonce_counter #(
    .START (NONCE_START),
    .LAST  (NONCE_LAST)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .value   (cnt_value),
    .is_last (cnt_last)
  );

  assign win = hash_meets_target(hash_q, target_q);

  // Next-state and output decisions; dropping start aborts any active search
  // and takes priority over a completing hash or a win in the same cycle.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    hash_d       = hash_q;
    finish_d     = finish_q;
    found_d      = found_q;
    result_d     = result_q;
    hash_start_d = 1'b0;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          target_d     = target;
          cnt_load     = 1'b1;
          hash_start_d = 1'b1;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = start ? WAIT : IDLE;
      end
      WAIT: begin
        if (!start) begin
          state_d = IDLE;
        end else if (hash_done) begin
          hash_d  = hash_out;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!start) begin
          state_d = IDLE;
        end else if (win) begin
          result_d = cnt_value;
          found_d  = 1'b1;
          finish_d = 1'b1;
          state_d  = DONE;
        end else if (cnt_last) begin
          result_d = NONCE_LAST;
          found_d  = 1'b0;
          finish_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_inc      = 1'b1;
          hash_start_d = 1'b1;
          state_d      = LAUNCH;
        end
      end
      DONE: begin
        if (!start) begin
          finish_d = 1'b0;
          found_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight search.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      target_q     <= '0;
      hash_q       <= '0;
      finish_q     <= 1'b0;
      found_q      <= 1'b0;
      result_q     <= '0;
      hash_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      hash_q       <= hash_d;
      finish_q     <= finish_d;
      found_q      <= found_d;
      result_q     <= result_d;
      hash_start_q <= hash_start_d;
    end
  end

  assign finish     = finish_q;
  assign found      = found_q;
  assign hash_start = hash_start_q;
  assign hash_nonce = cnt_value;
  assign nonce0     = result_q[7:0];
  assign nonce1     = result_q[15:8];
  assign nonce2     = result_q[23:16];
  assign nonce3     = result_q[31:24];

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Self-checking bench for nonce_search_ctrl with a behavioural hash engine
// whose results are looked up from a per-vector table indexed by nonce.
module tb_nonce_search_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] target = '0;
  logic        finish;
  logic        found;
  logic [7:0]  nonce0, nonce1, nonce2, nonce3;
  logic        hash_start;
  logic [31:0] hash_nonce;
  logic        hash_done = 1'b0;
  logic [23:0] hash_out = '0;

  typedef struct {
    logic [15:0] tgt;
    logic [23:0] r0, r1, r2, r3;
    int          lat;
    logic        expFound;
    logic [31:0] expNonce;
    int          expLaunches;
  } vec_t;

  vec_t        vecs[6];
  logic [23:0] resp[4];
  int          latency = 4;
  int          delay = 0;
  logic        pending = 1'b0;
  logic        abortOnDone = 1'b0;
  logic [31:0] launchNonce = '0;
  logic [31:0] launchLog[$];
  int          nonceErr = 0;
  int          cycleCount = 0;
  int          doneCycle = 0;
  int          assertions = 0;
  int          failures = 0;

  nonce_search_ctrl #(
    .NONCE_START (32'd0),
    .NONCE_LAST  (32'd3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .target     (target),
    .finish     (finish),
    .found      (found),
    .nonce0     (nonce0),
    .nonce1     (nonce1),
    .nonce2     (nonce2),
    .nonce3     (nonce3),
    .hash_start (hash_start),
    .hash_nonce (hash_nonce),
    .hash_done  (hash_done),
    .hash_out   (hash_out)
  );

  // Free-running clock and cycle counter for latency measurements.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Hash engine model: answers each launch `latency` cycles later with a
  // one-cycle hash_done, optionally dropping start in that same cycle.
  always @(negedge clk) begin
    hash_done = 1'b0;
    if (pending) begin
      delay = delay - 1;
      if (delay == 0) begin
        pending   = 1'b0;
        hash_done = 1'b1;
        hash_out  = resp[launchNonce[1:0]];
        doneCycle = cycleCount;
        if (hash_nonce !== launchNonce) nonceErr++;
        if (abortOnDone) begin
          start       = 1'b0;
          abortOnDone = 1'b0;
        end
      end
    end
    if (hash_start === 1'b1) begin
      pending     = 1'b1;
      delay       = latency;
      launchNonce = hash_nonce;
      launchLog.push_back(hash_nonce);
    end
  end

  // Single comparison point feeding the summary counters.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Load one vector into the engine model and start a fresh search.
  task automatic applyStimulus(input vec_t v);
    resp[0]  = v.r0;
    resp[1]  = v.r1;
    resp[2]  = v.r2;
    resp[3]  = v.r3;
    latency  = v.lat;
    target   = v.tgt;
    nonceErr = 0;
    launchLog.delete();
    start    = 1'b1;
  endtask

  // Run one vector to completion and check the result, hold and release.
  task automatic runVector(input int idx);
    vec_t v;
    bit   got;
    int   finishCycle;
    v = vecs[idx];
    got = 0;
    finishCycle = 0;
    applyStimulus(v);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (finish === 1'b1) begin
        got = 1;
        finishCycle = cycleCount;
        break;
      end
    end
    checkOutput($sformatf("v%0d_finish", idx), {31'd0, got}, 32'd1);
    checkOutput($sformatf("v%0d_found", idx), {31'd0, found}, {31'd0, v.expFound});
    checkOutput($sformatf("v%0d_nonce", idx), {nonce3, nonce2, nonce1, nonce0}, v.expNonce);
    checkOutput($sformatf("v%0d_launches", idx), launchLog.size(), v.expLaunches);
    for (int k = 0; k < v.expLaunches && k < launchLog.size(); k++)
      checkOutput($sformatf("v%0d_launch%0d_nonce", idx, k), launchLog[k], k);
    checkOutput($sformatf("v%0d_nonce_stable", idx), nonceErr, 0);
    checkOutput($sformatf("v%0d_done_to_finish", idx), finishCycle - doneCycle, 2);
    repeat (10) @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d_hold_finish", idx), {31'd0, finish}, 32'd1);
    checkOutput($sformatf("v%0d_no_relaunch", idx), launchLog.size(), v.expLaunches);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_release_finish", idx), {31'd0, finish}, 32'd0);
    checkOutput($sformatf("v%0d_release_found", idx), {31'd0, found}, 32'd0);
    checkOutput($sformatf("v%0d_release_nonce", idx), {nonce3, nonce2, nonce1, nonce0}, v.expNonce);
    @(posedge clk); #1;
  endtask

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, vector table, abort, reset mid-search.
  initial begin
    bit seen;
    int dones;

    vecs[0] = '{16'd50,    24'h00FF00, 24'h004000, 24'h003100, 24'h000000, 4, 1'b1, 32'd2, 3};
    vecs[1] = '{16'h0000,  24'h000000, 24'h000000, 24'h000000, 24'h000000, 2, 1'b0, 32'd3, 4};
    vecs[2] = '{16'h0031,  24'h003100, 24'h003000, 24'h000000, 24'h000000, 1, 1'b1, 32'd1, 2};
    vecs[3] = '{16'hFFFF,  24'hFFFE00, 24'h000000, 24'h000000, 24'h000000, 3, 1'b1, 32'd0, 1};
    vecs[4] = '{16'h1000,  24'h100000, 24'hFFFFFF, 24'h1000FF, 24'h123456, 2, 1'b0, 32'd3, 4};
    vecs[5] = '{16'h8000,  24'h800000, 24'h900000, 24'hA00000, 24'h7FFFFF, 1, 1'b1, 32'd3, 4};

    // Reset held with start high: nothing may launch.
    reset = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_finish", {31'd0, finish}, 32'd0);
    checkOutput("rst_found", {31'd0, found}, 32'd0);
    checkOutput("rst_hash_start", {31'd0, hash_start}, 32'd0);
    checkOutput("rst_nonce", {nonce3, nonce2, nonce1, nonce0}, 32'd0);
    checkOutput("rst_hash_nonce", hash_nonce, 32'd0);
    checkOutput("rst_no_launch", launchLog.size(), 0);
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_no_launch", launchLog.size(), 0);

    for (int i = 0; i < 6; i++) runVector(i);

    // Abort in the same cycle as a winning hash_done: result discarded.
    resp[0]  = 24'h000100;
    resp[1]  = 24'h000100;
    resp[2]  = 24'h000100;
    resp[3]  = 24'h000100;
    latency  = 3;
    target   = 16'd50;
    launchLog.delete();
    abortOnDone = 1'b1;
    start    = 1'b1;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (start == 1'b0) begin
        seen = 1;
        break;
      end
    end
    checkOutput("abort_reached", {31'd0, seen}, 32'd1);
    checkOutput("abort_finish", {31'd0, finish}, 32'd0);
    checkOutput("abort_found", {31'd0, found}, 32'd0);
    checkOutput("abort_nonce", {nonce3, nonce2, nonce1, nonce0}, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abort_idle_finish", {31'd0, finish}, 32'd0);
    checkOutput("abort_launches", launchLog.size(), 1);

    // Reset while in CHECK for the second nonce.
    resp[0]  = 24'h000000;
    resp[1]  = 24'h000000;
    latency  = 3;
    target   = 16'h0000;
    launchLog.delete();
    start    = 1'b1;
    dones = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (hash_done === 1'b1) dones++;
      if (dones == 2) break;
    end
    checkOutput("midrst_reached_check", dones, 2);
    checkOutput("midrst_pre_hash_nonce", hash_nonce, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_finish", {31'd0, finish}, 32'd0);
    checkOutput("midrst_found", {31'd0, found}, 32'd0);
    checkOutput("midrst_hash_start", {31'd0, hash_start}, 32'd0);
    checkOutput("midrst_nonce", {nonce3, nonce2, nonce1, nonce0}, 32'd0);
    checkOutput("midrst_hash_nonce", hash_nonce, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst_no_launch", launchLog.size(), 2);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
Sequencer for the mining hash datapath. On start it sweeps the 32-bit nonce space and launches the hash engine once per candidate nonce. Each hash result is compared against the 16-bit target. The block reports the first winning nonce on finish/nonce0..nonce3, or flags exhaustion. It sits between the system-level start/target/finish interface and the hash engine core.

Parameters:
NONCE_W, 32, nonce width; nonce0..nonce3 byte outputs require 32.
HASH_W, 24, hash engine result width.
TARGET_W, 16, target width; compared against hash_out[HASH_W-1 -: TARGET_W].
NONCE_START, 0, first nonce tried.
NONCE_LAST, 32'hFFFF_FFFF, last nonce tried before exhaustion.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  level request; high = search, low = abort or release.
target  in  16  difficulty threshold; sampled on the IDLE->LAUNCH transition.
finish  out  1  search concluded (found or exhausted); held while start stays high.
found  out  1  valid with finish; 1 = winning nonce, 0 = nonce space exhausted.
nonce0  out  8  result nonce bits [7:0].
nonce1  out  8  result nonce bits [15:8].
nonce2  out  8  result nonce bits [23:16].
nonce3  out  8  result nonce bits [31:24].
hash_start  out  1  one-cycle launch pulse to the hash engine.
hash_nonce  out  32  candidate nonce; stable from hash_start until hash_done.
hash_done  in  1  one-cycle pulse; hash_out valid in the same cycle.
hash_out  in  24  hash engine result.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE.
  - finish=0, found=0, hash_start=0.
  - nonce0..3=0, hash_nonce=NONCE_START, latched target=0.
  - Reset overrides everything, including mid-search and an in-flight hash; the engine result is ignored afterwards.
- State machine IDLE -> LAUNCH -> WAIT -> CHECK -> (LAUNCH | DONE):
  - IDLE: if start==1, latch target, set cur_nonce=NONCE_START, go to LAUNCH.
  - LAUNCH: drive hash_start=1 for exactly this cycle, hash_nonce=cur_nonce; go to WAIT.
  - WAIT: hold until hash_done==1; register hash_out; go to CHECK.
  - CHECK: win = (hash_out[23:8] < latched target), unsigned compare.
    - On win: capture cur_nonce into nonce0..3, set found=1, finish=1, go to DONE.
    - Else if cur_nonce==NONCE_LAST: set found=0, finish=1, nonce outputs=NONCE_LAST, go to DONE.
    - Else: cur_nonce+1, go to LAUNCH.
  - DONE: hold finish, found and nonce0..3; on start==0 clear finish and found (nonce outputs keep their value) and go to IDLE.
- Latency per nonce: 3 cycles plus the engine latency (LAUNCH 1, WAIT ≥1, CHECK 1). finish rises the cycle after CHECK.
- Abort: start==0 in LAUNCH, WAIT or CHECK returns to IDLE next cycle with finish=0. Nonce outputs are not updated.
  - An abort in the same cycle as hash_done or a win takes priority; the result is discarded.
- Increment: cur_nonce never wraps; NONCE_LAST is terminal.
- Boundary cases:
  - target==0: no hash can win, so the sweep runs to exhaustion.
  - hash_out[23:8]==target is not a win (strictly less than).
- Restart: start held high after an abort-free DONE does not re-launch. A new search needs start to drop to 0 and rise again.
- hash_done outside WAIT is ignored.

Decomposition:
- Package nonce_search_pkg:
  - state enum {IDLE, LAUNCH, WAIT, CHECK, DONE};
  - width localparams NONCE_W, HASH_W, TARGET_W;
  - function hash_meets_target(hash, target).
- One sub-module: nonce_counter (load NONCE_START, increment, terminal flag at NONCE_LAST).
- The FSM and result registers stay in the top module.

Test Plan:
- Reset: reset=0 for 2 cycles with start=1 -> finish=0, found=0, hash_start=0, nonce0..3=0; no launch until reset=1.
- Win on third nonce:
  - Setup: target=50; bench engine returns hash_out 24'h00FF00, 24'h004000, 24'h003100 for nonces 0, 1, 2, each 4 cycles after hash_start.
  - Required: exactly three hash_start pulses, found=1, nonce0=8'h02, nonce1..3=0, finish held until start=0.
- Exhaustion:
  - Setup: NONCE_START=0, NONCE_LAST=3, target=0.
  - Required: 4 launches with hash_nonce 0..3, then finish=1, found=0, nonce0=8'h03.
- Equality boundary: target=16'h0031 with hash_out=24'h003100 -> no win, next nonce launched.
- Abort: start dropped in WAIT in the same cycle as hash_done carrying a winning hash -> IDLE next cycle, finish stays 0, nonce outputs unchanged.
- Restart and reset mid-search:
  - Setup: after DONE, start stays high for 10 cycles.
  - Required: no hash_start pulses; after start toggles 0->1, the sweep restarts at nonce 0.
  - Reset asserted in CHECK -> IDLE and all outputs zero on the next edge.
